// File: rtl/pci_target_mem_if.sv
// PCI target bus bundle. Every target-driven line is split into a value and
// an output enable: an enable of 0 means the line is tri-stated, and the pad
// ring builds the real inout AD/TRDY/DEVSEL/STOP from these pairs. 'ad' is
// the value the initiator puts on AD.
interface pci_target_mem_if;
    logic        frame;
    logic        irdy;
    logic [3:0]  cbe;
    logic [31:0] ad;
    logic [31:0] ad_drv;
    logic        ad_en;
    logic        trdy;
    logic        trdy_en;
    logic        devsel;
    logic        devsel_en;
    logic        stop;
    logic        stop_en;

    modport master (
        output frame, irdy, cbe, ad,
        input  ad_drv, ad_en, trdy, trdy_en, devsel, devsel_en, stop, stop_en
    );

    modport slave (
        input  frame, irdy, cbe, ad,
        output ad_drv, ad_en, trdy, trdy_en, devsel, devsel_en, stop, stop_en
    );
endinterface

// File: rtl/pci_target_mem.sv
// PCI memory target: DEPTH x 32-bit words decoded at BASE_AD.
// Fast DEVSEL, programmable initial wait states, zero-wait bursts, and
// disconnect when a burst would run past the last word.
module pci_target_mem #(
    parameter logic [31:0] BASE_AD     = 32'hFFFF0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input logic              CLK,
    input logic              REST,
    pci_target_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    // Reads need at least one turnaround cycle before the target drives AD.
    localparam logic [1:0]  RD_WAIT  = (WAIT_STATES > 0) ? 2'(WAIT_STATES) : 2'd1;
    localparam logic [1:0]  WR_WAIT  = 2'(WAIT_STATES);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, BUSY, WAIT, DATA, DISC, RELEASE} state_t;

    state_t       state;
    logic [31:0]  mem [DEPTH];
    logic [AW:0]  idx;      // one spare bit so the index never wraps
    logic [1:0]   wcnt;
    logic         is_rd;
    logic [31:0]  ad_drv;
    logic         ad_en;
    logic         trdy_q, trdy_en;
    logic         devsel_q, devsel_en;
    logic         stop_q, stop_en;

    logic         hit;
    logic         xfer;
    logic         last;

    // Address must fall inside the aligned window and be a memory read/write.
    assign hit  = (bus.ad[31:AW+2] == BASE_AD[31:AW+2]) && (bus.cbe[3:1] == 3'b011);
    assign xfer = (state == DATA) && !bus.irdy && !trdy_q;
    assign last = (idx == LAST_IDX);

    assign bus.ad_drv    = ad_drv;
    assign bus.ad_en     = ad_en;
    assign bus.trdy      = trdy_q;
    assign bus.trdy_en   = trdy_en;
    assign bus.devsel    = devsel_q;
    assign bus.devsel_en = devsel_en;
    assign bus.stop      = stop_q;
    assign bus.stop_en   = stop_en;

    // Transaction FSM with registered bus outputs and read data.
    always_ff @(posedge CLK or posedge REST) begin
        if (REST) begin
            state     <= IDLE;
            idx       <= '0;
            wcnt      <= '0;
            is_rd     <= 1'b0;
            ad_drv    <= '0;
            ad_en     <= 1'b0;
            trdy_q    <= 1'b1;
            trdy_en   <= 1'b0;
            devsel_q  <= 1'b1;
            devsel_en <= 1'b0;
            stop_q    <= 1'b1;
            stop_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.frame) begin
                        if (hit) begin
                            state <= WAIT;
                            idx   <= {1'b0, bus.ad[AW+1:2]};
                            is_rd <= !bus.cbe[0];
                            wcnt  <= bus.cbe[0] ? WR_WAIT : RD_WAIT;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.frame && bus.irdy) state <= IDLE;
                end
                WAIT: begin
                    // Claim the bus; TRDY/STOP are owned (high) along with DEVSEL.
                    devsel_en <= 1'b1;
                    devsel_q  <= 1'b0;
                    trdy_en   <= 1'b1;
                    stop_en   <= 1'b1;
                    stop_q    <= 1'b1;
                    if (wcnt == 2'd0) begin
                        state  <= DATA;
                        trdy_q <= 1'b0;
                        if (is_rd) begin
                            ad_en  <= 1'b1;
                            ad_drv <= mem[idx[AW-1:0]];
                        end
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        idx <= idx + (AW+1)'(1);
                        if (bus.frame) begin
                            state    <= RELEASE;
                            trdy_q   <= 1'b1;
                            devsel_q <= 1'b1;
                            stop_q   <= 1'b1;
                            ad_en    <= 1'b0;
                        end else if (last) begin
                            state  <= DISC;
                            trdy_q <= 1'b1;
                            stop_q <= 1'b0;
                            ad_en  <= 1'b0;
                        end else if (is_rd) begin
                            ad_drv <= mem[idx[AW-1:0] + AW'(1)];
                        end
                    end
                end
                DISC: begin
                    if (bus.frame) begin
                        state    <= RELEASE;
                        trdy_q   <= 1'b1;
                        devsel_q <= 1'b1;
                        stop_q   <= 1'b1;
                    end
                end
                RELEASE: begin
                    state     <= IDLE;
                    trdy_en   <= 1'b0;
                    devsel_en <= 1'b0;
                    stop_en   <= 1'b0;
                    ad_en     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word storage; a write transfer merges only the enabled bytes.
    always_ff @(posedge CLK or posedge REST) begin
        if (REST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (xfer && !is_rd) begin
            for (int n = 0; n < 4; n++)
                if (!bus.cbe[n]) mem[idx[AW-1:0]][8*n +: 8] <= bus.ad[8*n +: 8];
        end
    end
endmodule

// File: tb/tb_pci_target_mem.sv
// Bench for pci_target_mem: two targets (no wait states / two wait states)
// on separate windows share one initiator; read data is scoreboarded.
module tb_pci_target_mem;
    localparam logic [31:0] BASE0 = 32'hFFFF0000;
    localparam logic [31:0] BASE1 = 32'h00002000;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame, irdy;
    logic [3:0]  cbe;
    logic [31:0] ad;
    logic        sel;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [2][16];
    logic [31:0] wdat [4];
    logic [3:0]  wbe [4];
    logic [31:0] exp_q [$];

    pci_target_mem_if b0();
    pci_target_mem_if b1();

    assign b0.frame = frame;
    assign b0.irdy  = irdy;
    assign b0.cbe   = cbe;
    assign b0.ad    = ad;
    assign b1.frame = frame;
    assign b1.irdy  = irdy;
    assign b1.cbe   = cbe;
    assign b1.ad    = ad;

    pci_target_mem #(.BASE_AD(BASE0), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .REST(rst), .bus(b0)
    );
    pci_target_mem #(.BASE_AD(BASE1), .DEPTH(16), .WAIT_STATES(2)) u_dut1 (
        .CLK(clk), .REST(rst), .bus(b1)
    );

    logic [3:0]  en0, en1, o_en;
    logic [2:0]  o_val;
    logic [31:0] o_ad;
    assign en0   = {b0.ad_en, b0.trdy_en, b0.devsel_en, b0.stop_en};
    assign en1   = {b1.ad_en, b1.trdy_en, b1.devsel_en, b1.stop_en};
    assign o_en  = sel ? en1 : en0;
    assign o_val = sel ? {b1.trdy, b1.devsel, b1.stop} : {b0.trdy, b0.devsel, b0.stop};
    assign o_ad  = sel ? b1.ad_drv : b0.ad_drv;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read scoreboard: a beat is taken on every edge with AD driven, TRDY=0, IRDY=0.
    always @(negedge clk) begin
        logic [31:0] e;
        if (o_en[3] && o_en[2] && !o_val[2] && !irdy) begin
            if (exp_q.size() == 0) chk("rd_extra", 32'h1, 32'h0);
            else begin
                e = exp_q.pop_front();
                chk("rd_data", o_ad, e);
            end
        end
    end

    task automatic drive_beat(input bit wr, input int b, input int n, input bit hold);
        irdy  = 1'b0;
        cbe   = wr ? wbe[b] : 4'h0;
        ad    = wr ? wdat[b] : 32'hDEADBEEF;
        frame = (b == n - 1) && !hold;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    endtask

    // One initiator transaction; stall_at inserts an IRDY wait before that beat,
    // hold keeps FRAME low so the target must disconnect.
    task automatic xact(input bit d, input logic [31:0] addr, input logic [3:0] cmd,
                        input int n, input bit hold, input int stall_at);
        bit wr, stall, seen;
        int base, beat, lat;
        wr   = cmd[0];
        base = int'(addr[5:2]);
        sel  = d;
        lat  = d ? 3 : (wr ? 1 : 2);
        if (!wr) for (int i = 0; i < n; i++) exp_q.push_back(model[d][base + i]);
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; cbe = cmd; ad = addr;
        @(posedge clk); #1;
        drive_beat(wr, 0, n, hold);
        @(negedge clk);
        chk("pre_devsel_z", 32'(o_en), 32'h0);
        beat = 0; stall = 0; seen = 0;
        for (int cyc = 1; cyc <= 40 && beat < n; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("devsel_e1", 32'({o_en[1], o_val[1]}), 32'h2);
            if (!seen && o_en[2] && !o_val[2]) begin
                seen = 1;
                chk("trdy_lat", cyc, lat);
            end
            if (stall) begin
                @(posedge clk); #1;
                stall = 0;
                drive_beat(wr, beat, n, hold);
            end else if (o_en[2] && !o_val[2] && !irdy) begin
                if (wr)
                    for (int k = 0; k < 4; k++)
                        if (!wbe[beat][k]) model[d][base + beat][8*k +: 8] = wdat[beat][8*k +: 8];
                @(posedge clk); #1;
                beat++;
                if (beat < n) begin
                    if (beat == stall_at) begin
                        irdy = 1'b1; cbe = 4'h0; ad = 32'h0BAD0BAD; stall = 1;
                    end else begin
                        drive_beat(wr, beat, n, hold);
                    end
                end
            end
        end
        chk("beats_done", beat, n);
        if (!hold) begin
            frame = 1'b1; irdy = 1'b1;
            @(negedge clk);
            chk("release", 32'({o_en, o_val}), 32'h3F);
        end else begin
            cbe = 4'h0; ad = 32'h0BAD0BAD;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("disc", 32'({o_en, o_val}), 32'h3C);
            end
            @(posedge clk); #1; frame = 1'b1;
            @(negedge clk);
            chk("disc_hold", 32'({o_en, o_val}), 32'h3C);
            @(posedge clk); #1; irdy = 1'b1;
            @(negedge clk);
            chk("release", 32'({o_en, o_val}), 32'h3F);
        end
        @(negedge clk);
        chk("idle_z", 32'({en0, en1}), 32'h0);
        chk("rd_left", exp_q.size(), 0);
    endtask

    // Unclaimed transaction: nothing may ever be driven.
    task automatic miss(input logic [31:0] addr, input logic [3:0] cmd);
        int bad;
        bad = 0;
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; cbe = cmd; ad = addr;
        @(posedge clk); #1;
        frame = 1'b1; irdy = 1'b0; cbe = 4'h0; ad = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if ({en0, en1} != 8'h0) bad++;
        end
        @(posedge clk); #1; irdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if ({en0, en1} != 8'h0) bad++;
        end
        chk("miss_z", bad, 0);
    endtask

    initial begin
        int nx;
        rst = 1'b1; frame = 1'b1; irdy = 1'b1; cbe = 4'h0; ad = 32'h0; sel = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h0; wbe[i] = 4'h0; end
        repeat (3) @(negedge clk);
        chk("reset_z", 32'({en0, en1}), 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Single full-word write, then a byte-masked merge over all-ones.
        wdat[0] = 32'hA5A5A5A5; wbe[0] = 4'b0000;
        xact(0, BASE0 + 32'd4, 4'b0111, 1, 0, -1);
        wdat[0] = 32'hFFFFFFFF;
        xact(0, BASE0 + 32'd8, 4'b0111, 1, 0, -1);
        wdat[0] = 32'h11223344; wbe[0] = 4'b1010;
        xact(0, BASE0 + 32'd8, 4'b0111, 1, 0, -1);
        // Burst read-back; AD[1:0] set to show it is ignored, one IRDY stall.
        xact(0, BASE0 + 32'd3, 4'b0110, 4, 0, 1);

        // Two-wait-state target: write burst with a stall and partial enables, read back.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'h5A5A0000 + 32'(i * 17) + 32'(i << 24);
            wbe[i]  = 4'b0000;
        end
        wbe[3] = 4'b0011;
        xact(1, BASE1, 4'b0111, 4, 0, 2);
        xact(1, BASE1, 4'b0110, 4, 0, -1);

        // Burst running off the end of memory with FRAME held low.
        wdat[0] = 32'hC0DE000E; wdat[1] = 32'hC0DE000F;
        wbe[0] = 4'b0000; wbe[1] = 4'b0000;
        xact(0, BASE0 + 32'd56, 4'b0111, 2, 1, -1);
        xact(0, BASE0 + 32'd56, 4'b0110, 2, 0, -1);

        // Out-of-window address and a non-memory command.
        miss(BASE0 + 32'd64, 4'b0111);
        miss(BASE0, 4'b0010);
        xact(0, BASE0, 4'b0110, 1, 0, -1);

        // Reset in the middle of a read burst.
        sel = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[0][i]);
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; cbe = 4'b0110; ad = BASE0;
        @(posedge clk); #1;
        irdy = 1'b0; cbe = 4'h0; ad = 32'hDEADBEEF;
        nx = 0;
        for (int c = 0; c < 20 && nx < 2; c++) begin
            @(negedge clk);
            if (o_en[2] && !o_val[2]) nx++;
        end
        chk("abort_beats", nx, 2);
        @(posedge clk); #3; rst = 1'b1; #1;
        chk("rst_async_z", 32'({en0, en1}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; frame = 1'b1; irdy = 1'b1;
        exp_q.delete();
        model_clear();
        xact(0, BASE0, 4'b0110, 4, 0, -1);
        xact(1, BASE1, 4'b0110, 2, 0, -1);
        wdat[0] = 32'h600DF00D; wbe[0] = 4'b0000;
        xact(0, BASE0 + 32'd12, 4'b0111, 1, 0, -1);
        xact(0, BASE0 + 32'd8, 4'b0110, 2, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pci_target_mem.md
PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 Parameter BASE_AD, default 32'hFFFF0000, SHALL be the first decoded byte address; it is DEPTH*4-aligned.
REQ-002 Parameter DEPTH, default 16, SHALL be the number of 32-bit words; it is a power of two, 4..256.
REQ-003 Parameter WAIT_STATES, default 0, SHALL be the number of extra cycles before the first TRDY; range 0..3.
REQ-004 CLK  input  1  SHALL be the single bus clock; all state changes occur on its rising edge.
REQ-005 REST  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 FRAME  input  1  SHALL be the active-low initiator frame.
REQ-007 IRDY  input  1  SHALL be the active-low initiator ready.
REQ-008 CBE  input  4  SHALL be the command in the address phase and the active-low byte enables in data phases.
REQ-009 AD  inout  32  SHALL carry the multiplexed address/data; driven only during read data phases.
REQ-010 TRDY  output  1  SHALL be the active-low target ready, tri-stated when not owned.
REQ-011 DEVSEL  output  1  SHALL be the active-low device select, tri-stated when not owned.
REQ-012 STOP  output  1  SHALL be the active-low target disconnect, tri-stated when not owned.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, WAIT, DATA, DISC and RELEASE.
REQ-014 Address phase SHALL be a rising edge in IDLE with FRAME=0; AD and CBE are latched there.
REQ-015 Hit SHALL require AD in [BASE_AD, BASE_AD+DEPTH*4-1] and CBE equal to 4'b0110 (read) or 4'b0111 (write).
REQ-016 On a miss, the FSM SHALL go IDLE->BUSY, stay until FRAME=1 and IRDY=1, and never drive any output.
REQ-017 On a hit, the FSM SHALL go to WAIT; the start index is AD[log2(DEPTH)+1:2]; AD[1:0] is ignored.
REQ-018 DEVSEL SHALL go low on the first edge after the address phase (fast decode).
REQ-019 TRDY SHALL go low after WAIT_STATES extra cycles for writes, and after max(WAIT_STATES,1) for reads (turnaround).
REQ-020 A data transfer SHALL occur on each rising edge in DATA with IRDY=0 and TRDY=0.
REQ-021 After the first transfer, TRDY SHALL stay low (zero-wait burst) until the transaction ends.
REQ-022 Write transfer: each byte of word[index] with CBE[n]=0 SHALL take AD[8n+7:8n]; bytes with CBE[n]=1 SHALL be kept.
REQ-023 Read: AD SHALL be driven with word[index] from the edge TRDY goes low, updated the edge after each transfer.
REQ-024 The index SHALL increment by 1 per transfer; it SHALL NOT wrap.
REQ-025 Normal end: a transfer with FRAME=1 SHALL go to RELEASE, driving TRDY/DEVSEL/STOP high for one cycle, AD tri-stated.
REQ-026 From RELEASE, the FSM SHALL go to IDLE with all outputs tri-stated.
REQ-027 Disconnect: a transfer of index DEPTH-1 with FRAME=0 SHALL go to DISC: STOP=0, TRDY=1, DEVSEL=0, AD tri-stated.
REQ-028 The FSM SHALL stay in DISC until FRAME=1 is sampled, then go to RELEASE.
REQ-029 IRDY=1 in DATA SHALL hold the index, memory and AD unchanged (initiator wait).
REQ-030 The target SHALL NOT drive AD on the edge following a write address phase or while in any state other than DATA-read.

Reset
REQ-031 While REST=1, the FSM SHALL be IDLE, TRDY/DEVSEL/STOP/AD tri-stated, index 0, all memory words 0.
REQ-032 REST asserted mid-transaction SHALL release all bus outputs asynchronously in the same cycle; no partial write is committed after assertion.
REQ-033 After REST deasserts, the first address phase SHALL be accepted on the next FRAME=0 edge.

Verification
REQ-034 Single write to BASE_AD+4, data 32'hA5A5A5A5, CBE=4'b0000, FRAME released at the data phase, WAIT_STATES=0 -> DEVSEL=0 and TRDY=0 one cycle later; word1=A5A5A5A5; RELEASE then Z.
REQ-035 Write of 32'h11223344 with CBE=4'b1010 over word2=32'hFFFFFFFF -> word2=32'hFF22FF44.
REQ-036 4-word read burst from BASE_AD, WAIT_STATES=2 -> TRDY low 3 cycles after the address phase; AD returns word0..word3 on consecutive IRDY=0 edges.
REQ-037 Write burst from BASE_AD+(DEPTH-2)*4 with FRAME held low -> 2 transfers, then STOP=0/TRDY=1 until FRAME=1, then RELEASE.
REQ-038 Address BASE_AD+DEPTH*4 and command 4'b0010 at BASE_AD -> no output ever leaves Z; BUSY until the bus idles.
REQ-039 REST pulse during the third beat of a read burst -> outputs Z immediately; memory reads back 0; the next transaction is decoded normally.
